ctrl_pipeline: RTL and testbench

Parametrised control-bundle pipeline that carries decoded control signals (memtoreg, memwrite, alusrc, regdst, regwrite, jal/jr/bal, memen, hilowrite, alucontrol, …) from the decode stage through STAGES downstream stages (default E, M, W). Every stage has its own valid bit, hold (stall) and flush control, and bubbles are inserted automatically where a stall boundary occurs. It replaces the fixed per-stage flop chains in the controller. Optional performance counters record stall, bubble and flush activity.

---
 rtl/ctrl_pipe_pkg.sv | 25 ++
 rtl/ctrl_pipe_stage.sv | 50 +++++
 rtl/ctrl_pipeline.sv | 130 +++++++++++++
 tb/tb_ctrl_pipeline.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared defaults, stage indices and control-bundle field offsets for ctrl_pipeline.
package ctrl_pipe_pkg;

    localparam int W_DEF      = 15;
    localparam int STAGES_DEF = 3;
    localparam int CNT_W_DEF  = 32;

    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    localparam int MEMTOREG       = 0;
    localparam int MEMWRITE       = 1;
    localparam int ALUSRC         = 2;
    localparam int REGDST         = 3;
    localparam int REGWRITE       = 4;
    localparam int JAL            = 5;
    localparam int JR             = 6;
    localparam int BAL            = 7;
    localparam int MEMEN          = 8;
    localparam int HILOWRITE      = 9;
    localparam int ALUCONTROL_LSB = 10;
    localparam int ALUCONTROL_W   = 5;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control-pipeline stage: W-bit bundle plus valid bit, one register deep.
// Priority flush > hold > bubble > load; an invalid entry always carries a zero bundle.
module ctrl_pipe_stage #(
    parameter int W = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold_i,
    input  logic         bubble_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    input  logic         valid_i,
    output logic [W-1:0] ctrl_o,
    output logic         valid_o
);

    logic [W-1:0] ctrl_q, ctrl_d;
    logic         valid_q, valid_d;

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (flush_i) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            if (bubble_i) begin
                ctrl_d  = '0;
                valid_d = 1'b0;
            end else begin
                ctrl_d  = d_i;
                valid_d = valid_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// Decode-to-writeback control-bundle pipeline with per-stage hold/flush and automatic bubbles.
// Define CTRL_PIPE_PERF_EN to add saturating stall/bubble/flush counters and perf_clr.
module ctrl_pipeline
    import ctrl_pipe_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int STAGES = STAGES_DEF
`ifdef CTRL_PIPE_PERF_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          in_ctrl,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES*W-1:0]   stage_ctrl,
    output logic [STAGES-1:0]     stage_valid
`ifdef CTRL_PIPE_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] bubble;
    logic [W-1:0]      ctrl_arr [STAGES];
    logic              dec_fire;

    // A stall anywhere downstream freezes every earlier stage.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            hold[k] = stall[k] | hold[k+1];
        end
    end

    assign in_ready = ~hold[0];
    assign dec_fire = in_valid & in_ready;

    always_comb begin
        bubble    = '0;
        bubble[0] = ~dec_fire;
        for (int k = 1; k < STAGES; k++) begin
            bubble[k] = hold[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0] d_k;
        logic         v_k;
        if (k == 0) begin : g_first
            assign d_k = in_ctrl;
            assign v_k = in_valid;
        end else begin : g_rest
            assign d_k = ctrl_arr[k-1];
            assign v_k = stage_valid[k-1];
        end

        ctrl_pipe_stage #(.W(W)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .hold_i   (hold[k]),
            .bubble_i (bubble[k]),
            .flush_i  (flush[k]),
            .d_i      (d_k),
            .valid_i  (v_k),
            .ctrl_o   (ctrl_arr[k]),
            .valid_o  (stage_valid[k])
        );

        assign stage_ctrl[k*W +: W] = ctrl_arr[k];
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
    logic [CNT_W:0]   stall_sum, bubble_sum, flush_sum, flush_inc;
    logic             bubble_any;

    // Only bubbles that actually land (stage not held, not flushed) are counted.
    always_comb begin
        bubble_any = 1'b0;
        flush_inc  = '0;
        for (int k = 1; k < STAGES; k++) begin
            bubble_any = bubble_any | (hold[k-1] & ~hold[k] & ~flush[k]);
        end
        for (int k = 0; k < STAGES; k++) begin
            flush_inc = flush_inc + (CNT_W+1)'(flush[k] & stage_valid[k]);
        end
        stall_sum  = {1'b0, stall_cnt_q}  + (CNT_W+1)'(in_valid & ~in_ready);
        bubble_sum = {1'b0, bubble_cnt_q} + (CNT_W+1)'(bubble_any);
        flush_sum  = {1'b0, flush_cnt_q}  + flush_inc;

        stall_cnt_d  = stall_sum[CNT_W]  ? '1 : stall_sum[CNT_W-1:0];
        bubble_cnt_d = bubble_sum[CNT_W] ? '1 : bubble_sum[CNT_W-1:0];
        flush_cnt_d  = flush_sum[CNT_W]  ? '1 : flush_sum[CNT_W-1:0];
        if (perf_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
            flush_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline; counter scenarios run only when CTRL_PIPE_PERF_EN is defined.
module tb_ctrl_pipeline;

    localparam int W = 15;
    localparam int S = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_ctrl;
    logic           in_valid;
    logic           in_ready;
    logic [S-1:0]   stall;
    logic [S-1:0]   flush;
    logic [S*W-1:0] stage_ctrl;
    logic [S-1:0]   stage_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef CTRL_PIPE_PERF_EN
    logic        perf_clr;
    logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
    logic        sat_in_ready;
    logic [S*W-1:0] sat_ctrl;
    logic [S-1:0]   sat_valid;
    logic [3:0]  sat_stall_cnt, sat_bubble_cnt, sat_flush_cnt;

    ctrl_pipeline #(.W(W), .STAGES(S), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .stage_ctrl(stage_ctrl), .stage_valid(stage_valid),
        .perf_clr(perf_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipeline #(.W(W), .STAGES(S), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(sat_in_ready),
        .stall(stall), .flush(flush), .stage_ctrl(sat_ctrl), .stage_valid(sat_valid),
        .perf_clr(perf_clr), .stall_cnt(sat_stall_cnt), .bubble_cnt(sat_bubble_cnt),
        .flush_cnt(sat_flush_cnt)
    );
`else
    ctrl_pipeline #(.W(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .stage_ctrl(stage_ctrl), .stage_valid(stage_valid)
    );
`endif

    // {valid, ctrl} of stage k as observed on the outputs
    function automatic logic [W:0] ent(input int k);
        return {stage_valid[k], stage_ctrl[k*W +: W]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] c);
        in_valid = v;
        in_ctrl  = c;
    endtask

    task automatic test_reset();
        logic [W:0] exp;
        rst = 1'b1; stall = '0; flush = '0;
        drive(1'b0, '0);
`ifdef CTRL_PIPE_PERF_EN
        perf_clr = 1'b0;
`endif
        tick(); tick();
        for (int k = 0; k < S; k++) begin
            checks++;
            if (ent(k) !== '0) begin
                errors++; $display("FAIL reset_stage%0d got=%h exp=0", k, ent(k));
            end
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(16'h0077 + i));
            tick();
        end
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < S; k++) begin
            checks++;
            if (ent(k) !== '0) begin
                errors++; $display("FAIL async_reset_stage%0d got=%h exp=0", k, ent(k));
            end
        end
        tick();
        checks++;
        if ({stage_valid, stage_ctrl} !== '0) begin
            errors++; $display("FAIL held_reset got=%h exp=0", {stage_valid, stage_ctrl});
        end
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(1'b1, W'(i + 1));
            else       drive(1'b0, '0);
            tick();
            exp = (i >= 2) ? {1'b1, W'(i - 1)} : '0;
            checks++;
            if (ent(2) !== exp) begin
                errors++; $display("FAIL stream_s2_edge%0d got=%h exp=%h", i + 1, ent(2), exp);
            end
        end
    endtask

    task automatic test_mid_stall();
        logic [W:0] exp [6][S];
        exp[0] = '{{1'b1, 15'h000A}, {1'b1, 15'h000B}, {1'b0, 15'h0000}};
        exp[1] = '{{1'b1, 15'h000A}, {1'b1, 15'h000B}, {1'b0, 15'h0000}};
        exp[2] = '{{1'b1, 15'h000D}, {1'b1, 15'h000A}, {1'b1, 15'h000B}};
        exp[3] = '{{1'b1, 15'h000E}, {1'b1, 15'h000D}, {1'b1, 15'h000A}};
        exp[4] = '{{1'b0, 15'h0000}, {1'b1, 15'h000E}, {1'b1, 15'h000D}};
        exp[5] = '{{1'b0, 15'h0000}, {1'b0, 15'h0000}, {1'b1, 15'h000E}};
        drive(1'b1, 15'h000C); tick();
        drive(1'b1, 15'h000B); tick();
        drive(1'b1, 15'h000A); tick();
        checks++;
        if ({ent(0), ent(1), ent(2)} !== {1'b1, 15'h000A, 1'b1, 15'h000B, 1'b1, 15'h000C}) begin
            errors++; $display("FAIL stall_fill got=%h", {ent(0), ent(1), ent(2)});
        end
        drive(1'b1, 15'h000D);
        for (int c = 0; c < 6; c++) begin
            stall = (c < 2) ? 3'b010 : 3'b000;
            if (c == 3) drive(1'b1, 15'h000E);
            if (c == 4) drive(1'b0, '0);
            #1;
            checks++;
            if (in_ready !== (c >= 2)) begin
                errors++; $display("FAIL stall_in_ready_c%0d got=%b exp=%b", c, in_ready, c >= 2);
            end
            tick();
            for (int k = 0; k < S; k++) begin
                checks++;
                if (ent(k) !== exp[c][k]) begin
                    errors++; $display("FAIL stall_c%0d_s%0d got=%h exp=%h", c, k, ent(k), exp[c][k]);
                end
            end
        end
    endtask

    task automatic test_flush_over_stall();
        drive(1'b1, 15'h1234); tick();
        checks++;
        if (ent(0) !== {1'b1, 15'h1234}) begin
            errors++; $display("FAIL fos_setup got=%h exp=%h", ent(0), {1'b1, 15'h1234});
        end
        drive(1'b1, 15'h0FFF);
        stall = 3'b001; flush = 3'b001;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL fos_in_ready got=%b exp=0", in_ready);
        end
        tick();
        stall = '0; flush = '0;
        checks++;
        if (ent(0) !== '0) begin
            errors++; $display("FAIL fos_s0_cleared got=%h exp=0", ent(0));
        end
        checks++;
        if (ent(1) !== '0) begin
            errors++; $display("FAIL fos_s1_bubble got=%h exp=0", ent(1));
        end
        tick();
        drive(1'b0, '0);
        checks++;
        if (ent(0) !== {1'b1, 15'h0FFF}) begin
            errors++; $display("FAIL fos_resume got=%h exp=%h", ent(0), {1'b1, 15'h0FFF});
        end
    endtask

    task automatic test_full_freeze();
        drive(1'b1, 15'h0101); tick();
        drive(1'b1, 15'h0102); tick();
        drive(1'b1, 15'h0103); tick();
        drive(1'b1, 15'h01FF);
        stall = 3'b100;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL freeze_in_ready_c%0d got=%b exp=0", c, in_ready);
            end
            tick();
            checks++;
            if ({ent(0), ent(1), ent(2)} !== {1'b1, 15'h0103, 1'b1, 15'h0102, 1'b1, 15'h0101}) begin
                errors++; $display("FAIL freeze_c%0d got=%h", c, {ent(0), ent(1), ent(2)});
            end
        end
        stall = '0;
        drive(1'b0, '0);
        tick();
        checks++;
        if ({ent(0), ent(1), ent(2)} !== {16'h0000, 1'b1, 15'h0103, 1'b1, 15'h0102}) begin
            errors++; $display("FAIL freeze_release got=%h", {ent(0), ent(1), ent(2)});
        end
    endtask

    task automatic test_bubble();
        logic         vin [7];
        logic [W-1:0] cin [7];
        logic [W:0]   exp [7];
        vin = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        cin = '{15'h0201, 15'h0202, 15'h7FFF, 15'h0203, 15'h0204, 15'h0000, 15'h0000};
        exp = '{{1'b1, 15'h0201}, {1'b1, 15'h0202}, 16'h0000, {1'b1, 15'h0203},
                {1'b1, 15'h0204}, 16'h0000, 16'h0000};
        for (int i = 0; i < 7; i++) begin
            drive(vin[i], cin[i]);
            tick();
            for (int k = 0; k < S; k++) begin
                if (i - k >= 0) begin
                    checks++;
                    if (ent(k) !== exp[i-k]) begin
                        errors++; $display("FAIL bubble_e%0d_s%0d got=%h exp=%h", i, k, ent(k), exp[i-k]);
                    end
                end
            end
        end
    endtask

`ifdef CTRL_PIPE_PERF_EN
    task automatic test_counters();
        drive(1'b0, '0);
        perf_clr = 1'b1; tick(); perf_clr = 1'b0;
        checks++;
        if ({stall_cnt, bubble_cnt, flush_cnt} !== '0) begin
            errors++; $display("FAIL cnt_clr0 got=%h exp=0", {stall_cnt, bubble_cnt, flush_cnt});
        end
        drive(1'b1, 15'h0011); tick(); tick(); tick();
        stall = 3'b010; tick(); tick(); stall = '0;
        drive(1'b0, '0); tick();
        checks++;
        if (stall_cnt !== 32'd2) begin
            errors++; $display("FAIL cnt_stall got=%0d exp=2", stall_cnt);
        end
        checks++;
        if (bubble_cnt !== 32'd2) begin
            errors++; $display("FAIL cnt_bubble got=%0d exp=2", bubble_cnt);
        end
        tick(); tick();
        drive(1'b1, 15'h0301); tick();
        drive(1'b1, 15'h0302); tick();
        drive(1'b0, '0);
        flush = 3'b111; tick(); flush = '0;
        checks++;
        if (flush_cnt !== 32'd2) begin
            errors++; $display("FAIL cnt_flush got=%0d exp=2", flush_cnt);
        end
        perf_clr = 1'b1; tick(); perf_clr = 1'b0;
        checks++;
        if ({stall_cnt, bubble_cnt, flush_cnt} !== '0) begin
            errors++; $display("FAIL cnt_clr1 got=%h exp=0", {stall_cnt, bubble_cnt, flush_cnt});
        end
        drive(1'b1, 15'h0400);
        stall = 3'b100;
        repeat (15) tick();
        checks++;
        if (sat_stall_cnt !== 4'd15) begin
            errors++; $display("FAIL cnt_sat_reach got=%0d exp=15", sat_stall_cnt);
        end
        tick();
        checks++;
        if (sat_stall_cnt !== 4'd15) begin
            errors++; $display("FAIL cnt_sat_hold got=%0d exp=15", sat_stall_cnt);
        end
        checks++;
        if (stall_cnt !== 32'd16) begin
            errors++; $display("FAIL cnt_wide got=%0d exp=16", stall_cnt);
        end
        stall = '0;
        drive(1'b0, '0);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_mid_stall();
        test_flush_over_stall();
        test_full_freeze();
        test_bubble();
`ifdef CTRL_PIPE_PERF_EN
        test_counters();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
